uart_frame_sched: RTL and testbench

//  Sequences the single-byte UART transmitter into framed telemetry packets: HDR0, HDR1, NUM_WORDS
//  16-bit words MSB-first, 8-bit checksum. Also shares the transmitter with a one-byte command

---
 rtl/uart_frame_sched.sv | 204 ++++++++++++++++++++
 tb/tb_uart_frame_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_sched.sv
// -----------------------------------------------------------------------------
// uart_frame_sched
//
// Shares one single-byte UART transmitter between two sources:
//   * framed telemetry packets: HDR0, HDR1, NUM_WORDS 16-bit words MSB-first,
//     then an 8-bit checksum (inverted wrap-around sum of the payload bytes),
//   * a one-byte command response, which wins only between frames.
// Frames start on a single-cycle request (snd_frm) or on a periodic tick.
// A trigger that arrives while a frame is pending or in flight is dropped.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   snd_frm             single-cycle frame request
//   per_en              enables the periodic frame trigger
//   frm_data            payload; word k = frm_data[16k+15:16k], word 0 first
//   rsp_req, rsp_byte   level request (held until rsp_ack) and its byte
//   rsp_ack             1-cycle pulse, coincident with trmt of the response
//   trmt, tx_data       start pulse and byte to UART_tx
//   tx_done             UART_tx done flag (may stay high between bytes)
//   frm_busy            frame accepted and not yet finished
//   frm_done            1-cycle pulse after the checksum byte completes
//   frm_drop            1-cycle pulse when a trigger is rejected
// -----------------------------------------------------------------------------
module uart_frame_sched #(
   parameter int          NUM_WORDS  = 4,
   parameter logic [7:0]  HDR0       = 8'hAA,
   parameter logic [7:0]  HDR1       = 8'h55,
   parameter int          PERIOD_CYC = 1_000_000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     snd_frm,
   input  logic                     per_en,
   input  logic [16*NUM_WORDS-1:0]  frm_data,
   input  logic                     rsp_req,
   input  logic [7:0]               rsp_byte,
   output logic                     rsp_ack,
   output logic                     trmt,
   output logic [7:0]               tx_data,
   input  logic                     tx_done,
   output logic                     frm_busy,
   output logic                     frm_done,
   output logic                     frm_drop
);

   localparam int LAST  = 2*NUM_WORDS + 2;   // index of the checksum byte
   localparam int IDX_W = 5;
   localparam int TMR_W = (PERIOD_CYC > 2) ? $clog2(PERIOD_CYC) : 1;

   typedef enum logic [1:0] {IDLE, SEND, WAIT} state_e;

   state_e                    state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic                      in_frm_q, in_frm_d;     // WAIT belongs to a frame byte
   logic                      first_q, first_d;       // first WAIT cycle (trmt cycle)
   logic                      pending_q, pending_d;
   logic [16*NUM_WORDS-1:0]   shadow_q, shadow_d;
   logic [7:0]                chk_q, chk_d;
   logic [TMR_W-1:0]          timer_q, timer_d;
   logic                      trmt_q, trmt_d;
   logic [7:0]                tx_data_q, tx_data_d;
   logic                      rsp_ack_q, rsp_ack_d;
   logic                      frm_done_q, frm_done_d;
   logic                      frm_drop_q, frm_drop_d;

   logic                      tick, trig, accept, clr_pend;
   logic [7:0]                frm_sum;

   // Byte idx of the frame held in the shadow register.
   function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0]        idx,
                                             input logic [16*NUM_WORDS-1:0] shadow,
                                             input logic [7:0]              chk);
      logic [IDX_W-1:0] j;
      int unsigned      pos;
      logic [7:0]       b;
      j   = idx - IDX_W'(2);
      pos = 16*int'(j >> 1) + (j[0] ? 0 : 8);   // even payload index = high byte
      if (idx == IDX_W'(0))         b = HDR0;
      else if (idx == IDX_W'(1))    b = HDR1;
      else if (idx == IDX_W'(LAST)) b = chk;
      else                          b = shadow[pos +: 8];
      return b;
   endfunction

   // Payload sum, taken at snapshot time so the checksum never depends on
   // frm_data changing while the frame is on the wire.
   always_comb begin
      frm_sum = 8'h00;
      for (int b = 0; b < 2*NUM_WORDS; b++) frm_sum = frm_sum + frm_data[8*b +: 8];
   end

   // Periodic trigger and frame acceptance.
   assign tick   = per_en && (timer_q == TMR_W'(PERIOD_CYC-1));
   assign trig   = snd_frm | tick;
   assign accept = trig & ~pending_q;

   always_comb begin
      timer_d    = per_en ? (tick ? '0 : timer_q + TMR_W'(1)) : '0;
      frm_drop_d = trig & pending_q;
      shadow_d   = accept ? frm_data : shadow_q;
      chk_d      = accept ? ~frm_sum : chk_q;
      pending_d  = accept ? 1'b1 : (clr_pend ? 1'b0 : pending_q);
   end

   // NOTE: every signal driven here gets a default first, so no path can leave
   // one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      in_frm_d   = in_frm_q;
      first_d    = 1'b0;
      trmt_d     = 1'b0;
      tx_data_d  = tx_data_q;
      rsp_ack_d  = 1'b0;
      frm_done_d = 1'b0;
      clr_pend   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rsp_req) begin
               trmt_d    = 1'b1;
               tx_data_d = rsp_byte;
               rsp_ack_d = 1'b1;
               in_frm_d  = 1'b0;
               first_d   = 1'b1;
               state_d   = WAIT;
            end else if (pending_q) begin
               trmt_d    = 1'b1;
               tx_data_d = frame_byte(idx_q, shadow_q, chk_q);
               in_frm_d  = 1'b1;
               first_d   = 1'b1;
               state_d   = WAIT;
            end
         end
         // tx_done seen during the trmt cycle is the previous byte's stale flag.
         WAIT: begin
            if (!first_q && tx_done) begin
               if (in_frm_q && (idx_q < IDX_W'(LAST))) begin
                  state_d = SEND;
               end else begin
                  state_d = IDLE;
                  if (in_frm_q) begin
                     frm_done_d = 1'b1;
                     clr_pend   = 1'b1;
                     idx_d      = '0;
                     in_frm_d   = 1'b0;
                  end
               end
            end
         end
         SEND: begin
            trmt_d    = 1'b1;
            tx_data_d = frame_byte(idx_q + IDX_W'(1), shadow_q, chk_q);
            idx_d     = idx_q + IDX_W'(1);
            first_d   = 1'b1;
            state_d   = WAIT;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   // NOTE: the shadow payload is reset along with the control state; it is a
   // plain register, not a RAM, and a known value keeps tx_data deterministic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         in_frm_q   <= 1'b0;
         first_q    <= 1'b0;
         pending_q  <= 1'b0;
         shadow_q   <= '0;
         chk_q      <= 8'h00;
         timer_q    <= '0;
         trmt_q     <= 1'b0;
         tx_data_q  <= 8'h00;
         rsp_ack_q  <= 1'b0;
         frm_done_q <= 1'b0;
         frm_drop_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         in_frm_q   <= in_frm_d;
         first_q    <= first_d;
         pending_q  <= pending_d;
         shadow_q   <= shadow_d;
         chk_q      <= chk_d;
         timer_q    <= timer_d;
         trmt_q     <= trmt_d;
         tx_data_q  <= tx_data_d;
         rsp_ack_q  <= rsp_ack_d;
         frm_done_q <= frm_done_d;
         frm_drop_q <= frm_drop_d;
      end
   end

   assign trmt     = trmt_q;
   assign tx_data  = tx_data_q;
   assign rsp_ack  = rsp_ack_q;
   assign frm_busy = pending_q;
   assign frm_done = frm_done_q;
   assign frm_drop = frm_drop_q;

endmodule

// File: tb/tb_uart_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_sched
//
// Drives uart_frame_sched (NUM_WORDS=2, short period) with a behavioural UART
// that holds tx_done between bytes and uses random byte times. Transmitted
// bytes are collected and compared with an expected stream built from the
// frame rules: headers, payload MSB-first, inverted payload sum, responses.
// -----------------------------------------------------------------------------
module tb_uart_frame_sched;

   localparam int NW  = 2;
   localparam int PER = 3000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          snd_frm = 1'b0;
   logic          per_en = 1'b0;
   logic [31:0]   frm_data = '0;
   logic          rsp_req = 1'b0;
   logic [7:0]    rsp_byte = '0;
   logic          tx_done = 1'b0;
   logic          rsp_ack, trmt, frm_busy, frm_done, frm_drop;
   logic [7:0]    tx_data;

   uart_frame_sched #(.NUM_WORDS(NW), .HDR0(8'hAA), .HDR1(8'h55), .PERIOD_CYC(PER)) dut (
      .clk(clk), .rst_n(rst_n), .snd_frm(snd_frm), .per_en(per_en), .frm_data(frm_data),
      .rsp_req(rsp_req), .rsp_byte(rsp_byte), .rsp_ack(rsp_ack), .trmt(trmt),
      .tx_data(tx_data), .tx_done(tx_done), .frm_busy(frm_busy), .frm_done(frm_done),
      .frm_drop(frm_drop));

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // ---------------- behavioural UART_tx ----------------
   bit u_busy = 0;
   int u_cnt  = 0;
   always @(posedge clk) begin
      if (!rst_n) begin
         u_busy = 0;
         #1 tx_done = 1'b0;
      end else if (trmt) begin
         check("trmt_while_uart_busy", 32'(u_busy), 32'd0);
         u_busy = 1;
         u_cnt  = $urandom_range(3, 20);
         #1 tx_done = 1'b0;
      end else if (u_busy) begin
         u_cnt--;
         if (u_cnt == 0) begin
            u_busy = 0;
            #1 tx_done = 1'b1;
         end
      end
   end

   // ---------------- monitor ----------------
   int          cyc = 0;
   always @(posedge clk) cyc++;

   logic [8:0]  got_q[$];        // {rsp_ack, tx_data} per trmt
   logic [8:0]  exp_q[$];
   int          done_cnt = 0, drop_cnt = 0, busy_rise = 0, last_rise = 0;
   int          exp_done = 0, exp_drop = 0;
   logic        busy_prev = 1'b0;

   always @(negedge clk) begin
      if (trmt) got_q.push_back({rsp_ack, tx_data});
      if (rsp_ack) rsp_req = 1'b0;
      if (frm_done) done_cnt++;
      if (frm_drop) drop_cnt++;
      if (frm_busy && !busy_prev) begin
         busy_rise++;
         last_rise = cyc;
      end
      busy_prev = frm_busy;
   end

   // ---------------- reference model ----------------
   task automatic add_frame(input logic [31:0] d);
      logic [7:0] sum, b;
      sum = 8'h00;
      exp_q.push_back({1'b0, 8'hAA});
      exp_q.push_back({1'b0, 8'h55});
      for (int w = 0; w < NW; w++) begin
         for (int h = 1; h >= 0; h--) begin
            b   = d[16*w + 8*h +: 8];
            sum = sum + b;
            exp_q.push_back({1'b0, b});
         end
      end
      exp_q.push_back({1'b0, ~sum});
      exp_done++;
   endtask

   task automatic add_rsp(input logic [7:0] b);
      exp_q.push_back({1'b1, b});
   endtask

   // ---------------- helpers ----------------
   task automatic pulse_snd();
      @(negedge clk) snd_frm = 1'b1;
      @(negedge clk) snd_frm = 1'b0;
   endtask

   task automatic wait_bytes(input int n);
      int k = 0;
      while (got_q.size() < n && k < 5000) begin
         @(negedge clk);
         k++;
      end
      check("wait_bytes", 32'(got_q.size() >= n), 32'd1);
   endtask

   task automatic wait_rise(input int prev);
      int k = 0;
      while (busy_rise == prev && k < PER + 200) begin
         @(negedge clk);
         k++;
      end
      check("wait_busy_rise", 32'(busy_rise > prev), 32'd1);
   endtask

   task automatic finish_stream(input string tag);
      wait_bytes(exp_q.size());
      repeat (30) @(negedge clk);
      check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         check({tag, "_byte"}, (i < got_q.size()) ? 32'(got_q[i]) : 32'hxxxx_xxxx, 32'(exp_q[i]));
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
      check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
      check({tag, "_busy_low"}, 32'(frm_busy), 32'd0);
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_trmt"},     32'(trmt),     32'd0);
      check({tag, "_tx_data"},  32'(tx_data),  32'd0);
      check({tag, "_rsp_ack"},  32'(rsp_ack),  32'd0);
      check({tag, "_frm_busy"}, 32'(frm_busy), 32'd0);
      check({tag, "_frm_done"}, 32'(frm_done), 32'd0);
      check({tag, "_frm_drop"}, 32'(frm_drop), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] d;
      int          k, prev, t0;
      bit          rsp_first, extra;

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Directed frame, latency, drop on mid-frame request, payload change ignored.
      frm_data = 32'hABCD_1234;
      pulse_snd();
      check("latency_no_trmt_yet", 32'(trmt), 32'd0);
      check("busy_after_accept", 32'(frm_busy), 32'd1);
      @(negedge clk);
      check("latency_trmt", 32'(trmt), 32'd1);
      check("first_byte_hdr0", 32'(tx_data), 32'hAA);
      add_frame(32'hABCD_1234);
      wait_bytes(3);
      frm_data = 32'h5A5A_C3C3;
      pulse_snd();
      exp_drop++;
      wait_bytes(7);
      check("directed_checksum", (got_q.size() >= 7) ? 32'(got_q[6]) : 32'hxxxx_xxxx, 32'h041);
      finish_stream("directed");

      // Response in the same cycle as the frame request: response first.
      d = $urandom;
      @(negedge clk);
      frm_data = d; rsp_byte = 8'h06; rsp_req = 1'b1; snd_frm = 1'b1;
      @(negedge clk) snd_frm = 1'b0;
      add_rsp(8'h06);
      add_frame(d);
      finish_stream("rsp_first");

      // Response raised mid-frame: waits for the checksum byte.
      d = $urandom;
      frm_data = d;
      pulse_snd();
      add_frame(d);
      wait_bytes(3);
      rsp_byte = 8'h06; rsp_req = 1'b1;
      add_rsp(8'h06);
      finish_stream("rsp_mid");

      // Randomised frames with optional response and rejected extra requests.
      for (int it = 0; it < 8; it++) begin
         d         = $urandom;
         rsp_first = 1'($urandom_range(0, 1));
         extra     = 1'($urandom_range(0, 1));
         @(negedge clk);
         frm_data = d;
         snd_frm  = 1'b1;
         if (rsp_first) begin
            rsp_byte = 8'($urandom);
            rsp_req  = 1'b1;
            add_rsp(rsp_byte);
         end
         @(negedge clk) snd_frm = 1'b0;
         add_frame(d);
         if (extra) begin
            k = $urandom_range(2, 6);
            wait_bytes(k);
            frm_data = $urandom;
            pulse_snd();
            exp_drop++;
         end
         finish_stream("random");
      end

      // Periodic trigger: exact interval, drop while busy, restart from zero.
      frm_data = 32'h0F1E_2D3C;
      prev = busy_rise;
      @(negedge clk) per_en = 1'b1;
      t0 = cyc;
      wait_rise(prev);
      check("per_first_interval", 32'(last_rise - t0), 32'(PER));
      add_frame(frm_data);
      prev = busy_rise; t0 = last_rise;
      wait_rise(prev);
      check("per_interval", 32'(last_rise - t0), 32'(PER));
      add_frame(frm_data);
      t0 = last_rise;
      while (cyc < t0 + PER - 20) @(negedge clk);
      pulse_snd();
      add_frame(frm_data);
      exp_drop++;                 // the tick lands while this frame is busy
      while (cyc < t0 + PER + 50) @(negedge clk);
      per_en = 1'b0;
      finish_stream("periodic");
      prev = busy_rise;
      repeat (PER + 500) @(negedge clk);
      check("per_disabled_no_frame", 32'(busy_rise), 32'(prev));
      @(negedge clk) per_en = 1'b1;
      t0 = cyc;
      wait_rise(prev);
      check("per_restart_interval", 32'(last_rise - t0), 32'(PER));
      add_frame(frm_data);
      @(negedge clk) per_en = 1'b0;
      finish_stream("per_restart");

      // Reset during the third byte abandons the frame; next frame is complete.
      frm_data = 32'h1357_9BDF;
      pulse_snd();
      wait_bytes(3);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      got_q.delete();
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;
      d = $urandom;
      frm_data = d;
      pulse_snd();
      add_frame(d);
      finish_stream("after_reset");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
